mem_port_arbiter: RTL and testbench

Parametrised multi-channel memory arbiter and byte serialiser between the pipeline's memory clients (instruction fetch, load, store, future cache refill) and the 8-bit external RAM/IO bus. It generalises the fixed two-client inst/data split to NUM_CH requesters, each of which can issue 1/2/4-byte reads or writes. The block adds per-channel read abort for branch redirect and selectable fixed-priority or round-robin arbitration.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_picker.sv | 35 +++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, width codes and byte-count decode for mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

  localparam logic [2:0] WIDTH_B = 3'd1;
  localparam logic [2:0] WIDTH_H = 3'd2;
  localparam logic [2:0] WIDTH_W = 3'd4;

  // Anything other than a byte or halfword code is treated as a full word.
  function automatic logic [2:0] byte_count(input logic [2:0] w);
    return (w == WIDTH_B || w == WIDTH_H) ? w : WIDTH_W;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational grant selection; round-robin from ptr when MEM_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module mem_arb_picker #(
  parameter int NUM_CH = 3,
  parameter int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic [PW-1:0]     ptr,
`endif
  output logic [PW-1:0]     idx,
  output logic              ok
);

  int j;

  // Walk offsets from the far end so the nearest requester overwrites last and wins.
  always_comb begin
    idx = '0;
    ok = 1'b0;
    j = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
`ifdef MEM_ARB_RR_EN
      j = (int'(ptr) + k) % NUM_CH;
`else
      j = k;
`endif
      if (req[j]) begin
        idx = PW'(j);
        ok = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: NUM_CH-client arbiter serialising 1/2/4-byte accesses onto an 8-bit RAM bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [3*NUM_CH-1:0]      req_width,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  input  logic [NUM_CH-1:0]        abort,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     busy,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            state;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     pick;
  logic              pick_ok;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        cnt;
  logic [1:0]        last;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              arb;
  logic              in_acc;
  logic              abort_own;

`ifdef MEM_ARB_RR_EN
  logic [PW-1:0] ptr;
`endif

  assign arb = (state == IDLE) || (state == DONE);
  assign in_acc = state == ACCESS;
  assign abort_own = abort[owner] && !we;

  mem_arb_picker #(.NUM_CH(NUM_CH), .PW(PW)) u_picker (
    .req (req_valid & ~abort),
`ifdef MEM_ARB_RR_EN
    .ptr (ptr),
`endif
    .idx (pick),
    .ok  (pick_ok)
  );

  // The grant pulse depends on live inputs, so it is masked while frozen or in reset.
  assign req_ready = (arb && rdy && pick_ok && !rst) ? NUM_CH'(1) << pick : '0;
  assign rsp_valid = (state == DONE) ? NUM_CH'(1) << owner : '0;
  assign rsp_rdata = (state == DONE && !we) ? rdata : '0;
  assign busy = state != IDLE;
  assign mem_a = in_acc ? addr + ADDR_W'(cnt) : '0;
  assign mem_wr = in_acc && we && rdy;
  assign mem_dout = (in_acc && we) ? wdata[{cnt, 3'd0} +: 8] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      addr <= '0;
      cnt <= '0;
      last <= '0;
      we <= 1'b0;
      wdata <= '0;
      rdata <= '0;
`ifdef MEM_ARB_RR_EN
      ptr <= '0;
`endif
    end else if (rdy) begin
      if (arb) begin
        if (pick_ok) begin
          state <= ACCESS;
          owner <= pick;
          addr <= req_addr[ADDR_W*pick +: ADDR_W];
          we <= req_we[pick];
          wdata <= req_wdata[32*pick +: 32];
          last <= 2'(byte_count(req_width[3*pick +: 3]) - 3'd1);
          cnt <= '0;
          rdata <= '0;
`ifdef MEM_ARB_RR_EN
          ptr <= (pick == PW'(NUM_CH - 1)) ? '0 : pick + 1'b1;
`endif
        end else begin
          state <= IDLE;
        end
      end else if (abort_own) begin
        state <= IDLE;
      end else if (in_acc) begin
        // mem_din carries the byte addressed in the previous advancing cycle.
        if (!we && cnt != 2'd0) rdata[{cnt - 2'd1, 3'd0} +: 8] <= mem_din;
        cnt <= cnt + 2'd1;
        if (cnt == last) state <= we ? DONE : DRAIN;
      end else begin
        rdata[{last, 3'd0} +: 8] <= mem_din;
        state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int NUM_CH = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rdy = 1'b1;
  logic [NUM_CH-1:0]    req_valid = '0;
  logic [NUM_CH-1:0]    req_we = '0;
  logic [3*NUM_CH-1:0]  req_width = '0;
  logic [32*NUM_CH-1:0] req_addr = '0;
  logic [32*NUM_CH-1:0] req_wdata = '0;
  logic [NUM_CH-1:0]    abort = '0;
  logic [NUM_CH-1:0]    req_ready;
  logic [NUM_CH-1:0]    rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 busy;
  logic [7:0]           mem_din = '0;
  logic [7:0]           mem_dout;
  logic [31:0]          mem_a;
  logic                 mem_wr;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;
  logic [7:0] ram [logic [31:0]];

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_we(req_we),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata), .abort(abort),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : (a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A);
  endfunction

  // Synchronous RAM: byte at the address seen at an edge is presented during the following cycle.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= rd(mem_a);
  end

  function automatic logic [NUM_CH-1:0] oh(input int c);
    return NUM_CH'(1) << c;
  endfunction

  function automatic int ref_pick(input logic [NUM_CH-1:0] r);
    int start;
`ifdef MEM_ARB_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int off = 0; off < NUM_CH; off++)
      if (r[(start + off) % NUM_CH]) return (start + off) % NUM_CH;
    return -1;
  endfunction

  task automatic granted(input int c);
    m_ptr = (c + 1) % NUM_CH;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input bit w, input logic [2:0] wc, input logic [31:0] a, input logic [31:0] wd);
    req_we[ch] = w;
    req_width[3*ch +: 3] = wc;
    req_addr[32*ch +: 32] = a;
    req_wdata[32*ch +: 32] = wd;
  endtask

  // One complete transaction from an idle arbiter; stall_at >= 0 freezes the bus 3 cycles before that byte.
  task automatic do_txn(input int ch, input bit w, input logic [2:0] wc, input logic [31:0] a,
                        input logic [31:0] wd, input int stall_at);
    int nb;
    logic [31:0] exp_r;
    logic [31:0] ai;
    nb = (wc == 3'd1 || wc == 3'd2) ? int'(wc) : 4;
    exp_r = '0;
    for (int i = 0; i < nb; i++) begin
      ai = a + 32'(i);
      exp_r[8*i +: 8] = rd(ai);
    end
    set_req(ch, w, wc, a, wd);
    req_valid[ch] = 1'b1;
    #1;
    chk("grant", req_ready, oh(ch));
    granted(ch);
    step();
    req_valid[ch] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      ai = a + 32'(i);
      if (i == stall_at) begin
        rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("stall_wr", mem_wr, 0);
          chk("stall_a", mem_a, ai);
          step();
        end
        rdy = 1'b1;
      end
      #1;
      chk("acc_a", mem_a, ai);
      chk("acc_wr", mem_wr, w);
      chk("acc_dout", mem_dout, w ? wd[8*i +: 8] : 8'h00);
      chk("acc_rsp", rsp_valid, 0);
      step();
    end
    if (!w) begin
      chk("drain_busy", busy, 1);
      chk("drain_rsp", rsp_valid, 0);
      chk("drain_a", mem_a, 0);
      step();
    end
    chk("done_rsp", rsp_valid, oh(ch));
    chk("done_data", rsp_rdata, w ? 32'h0 : exp_r);
    if (w)
      for (int i = 0; i < nb; i++) begin
        ai = a + 32'(i);
        chk("ram_byte", rd(ai), wd[8*i +: 8]);
      end
    step();
    chk("idle_busy", busy, 0);
    chk("idle_a", mem_a, 0);
  endtask

  initial begin
    int prev;
    int e;
    int t;
    // Reset state
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_bus", {mem_a, mem_dout, mem_wr}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Directed read and wrapping writes
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    do_txn(1, 1'b0, 3'd4, 32'h100, 32'h0, -1);
    chk("rd_word", {ram[32'h103], ram[32'h102], ram[32'h101], ram[32'h100]}, 32'h44332211);
    do_txn(2, 1'b1, 3'd2, 32'h1FFFF, 32'hBEEF, -1);
    do_txn(2, 1'b1, 3'd2, 32'hFFFFFFFF, 32'hBEEF, -1);
    chk("wrap_byte", rd(32'h0), 8'hBE);

    // Random transactions, including illegal width codes and wrap-prone addresses
    for (int n = 0; n < 20; n++) begin
      int ch;
      bit w;
      logic [31:0] a;
      ch = int'($urandom_range(0, NUM_CH - 1));
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      do_txn(ch, w, 3'($urandom_range(0, 7)), a, $urandom, w ? int'($urandom_range(0, 4)) : -1);
    end

    // All channels requesting one-byte reads continuously
    for (int c = 0; c < NUM_CH; c++) set_req(c, 1'b0, 3'd1, 32'h200 + 32'(16 * c), 32'h0);
    req_valid = '1;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      #1;
      e = ref_pick(req_valid);
      chk("cont_grant", req_ready, oh(e));
      if (prev >= 0) chk("cont_rsp", rsp_valid, oh(prev));
      granted(e);
      prev = e;
      step();
      step();
      step();
    end
    req_valid = '0;
    #1;
    chk("cont_last_rsp", rsp_valid, oh(prev));
    chk("cont_no_grant", req_ready, 0);
    step();

    // Abort excludes a channel from arbitration, kills its read, ignored for writes
    set_req(0, 1'b0, 3'd4, 32'h300, 32'h0);
    set_req(1, 1'b1, 3'd1, 32'h400, 32'hA5);
    req_valid = 3'b001;
    abort = 3'b001;
    #1;
    chk("abort_excl", req_ready, 0);
    step();
    chk("abort_excl_idle", busy, 0);
    abort = 3'b000;
    #1;
    chk("ab_grant0", req_ready, oh(0));
    granted(0);
    step();
    req_valid = 3'b010;
    #1;
    chk("ab_b0", mem_a, 32'h300);
    step();
    chk("ab_b1", mem_a, 32'h301);
    abort = 3'b001;
    step();
    abort = 3'b000;
    #1;
    chk("ab_idle", busy, 0);
    chk("ab_no_rsp", rsp_valid, 0);
    chk("ab_grant1", req_ready, oh(1));
    granted(1);
    step();
    req_valid = 3'b000;
    abort = 3'b010;
    #1;
    chk("ab_wr", {mem_wr, mem_dout, mem_a}, {1'b1, 8'hA5, 32'h400});
    step();
    abort = 3'b000;
    chk("ab_wr_rsp", rsp_valid, oh(1));
    step();

    // Freeze mid-write
    do_txn(2, 1'b1, 3'd4, 32'h500, 32'hCAFEF00D, 1);

    // Asynchronous reset in the middle of a read
    set_req(1, 1'b0, 3'd4, 32'h600, 32'h0);
    req_valid = 3'b010;
    #1;
    chk("rr_grant", req_ready, oh(1));
    step();
    set_req(0, 1'b1, 3'd1, 32'h700, 32'h77);
    req_valid = 3'b111;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_bus", {mem_a, mem_dout, mem_wr, rsp_valid}, 0);
    m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", req_ready, oh(0));
    step();
    req_valid = '0;
    t = 0;
    while (busy && t < 20) begin
      step();
      t++;
    end
    chk("post_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
